axi_sram_write_slave: RTL and testbench



---
 rtl/axi_sram_write_slave_if.sv | 48 ++++
 rtl/axi_sram_write_slave.sv | 149 ++++++++++++++
 tb/tb_axi_sram_write_slave.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_write_slave_if.sv
// AXI4 write-path channels (AW, W, B) for one slave port.
// The master modport is the interconnect side; the slave modport is the endpoint.
interface axi_sram_write_slave_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    // Write-address channel
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [LEN_W-1:0]    AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    // Write-data channel
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    // Write-response channel
    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_sram_write_slave.sv
// AXI4 write slave driving a single-port word-addressed SRAM.
// One burst at a time: AW handshake, W beats written straight to the SRAM,
// then a B response carrying the burst ID. Length mismatches give SLVERR.
module axi_sram_write_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int MEM_AW = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_sram_write_slave_if.slave bus,
    output logic                  SRAM_CS,
    output logic [DATA_W/8-1:0]   SRAM_WEB,
    output logic [MEM_AW-1:0]     SRAM_A,
    output logic [DATA_W-1:0]     SRAM_DI
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t            state;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;

    logic [ID_W-1:0]   id_q;
    logic [MEM_AW-1:0] word_q;   // current SRAM word index; wraps modulo 2^MEM_AW
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W:0]    cnt;      // beats accepted so far, saturating
    logic              err_q;

    logic              w_hs;
    logic              in_range;

    // Only the word index of AWADDR matters; size and burst type are fixed.
    logic unused_inputs;
    assign unused_inputs = ^{bus.AWSIZE, bus.AWBURST,
                             bus.AWADDR[1:0], bus.AWADDR[ADDR_W-1:MEM_AW+2]};

    // A beat is taken only when not in reset, so a reset mid-burst blocks the write.
    assign w_hs     = bus.WVALID && wready_q && !rst;
    assign in_range = (cnt <= {1'b0, len_q});

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BID     = bid_q;
    assign bus.BRESP   = bresp_q;

    // Burst FSM with registered handshake outputs and burst bookkeeping.
    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            id_q      <= '0;
            word_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.AWVALID && awready_q) begin
                        id_q      <= bus.AWID;
                        word_q    <= bus.AWADDR[MEM_AW+1:2];
                        len_q     <= bus.AWLEN;
                        cnt       <= '0;
                        err_q     <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        state     <= DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end

                DATA: begin
                    if (w_hs) begin
                        word_q <= word_q + 1'b1;
                        if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (!in_range) begin
                            err_q <= 1'b1;
                        end
                        if (bus.WLAST) begin
                            // Out-of-range beats always have cnt != len_q, so this
                            // comparison also covers an error raised on this beat.
                            bresp_q  <= (err_q || (cnt != {1'b0, len_q})) ? RESP_SLVERR
                                                                          : RESP_OKAY;
                            bid_q    <= id_q;
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (bus.BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // SRAM write port: active in the same cycle as an in-range W handshake.
    always_comb begin
        // NOTE: idle values are assigned first so no path leaves an output unassigned (no latch).
        SRAM_CS  = 1'b0;
        SRAM_WEB = {STRB_W{1'b1}};
        SRAM_A   = '0;
        SRAM_DI  = '0;
        if (w_hs && in_range) begin
            SRAM_CS  = 1'b1;
            SRAM_WEB = ~bus.WSTRB;
            SRAM_A   = word_q;
            SRAM_DI  = bus.WDATA;
        end
    end

endmodule

// File: tb/tb_axi_sram_write_slave.sv
// Directed bench for axi_sram_write_slave: single beat, INCR burst,
// backpressure, length errors, address wrap and reset mid-burst.
module tb_axi_sram_write_slave;

    localparam int ID_W   = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int MEM_AW = 14;

    logic clk = 1'b0;
    logic rst;

    logic              sram_cs;
    logic [3:0]        sram_web;
    logic [MEM_AW-1:0] sram_a;
    logic [DATA_W-1:0] sram_di;

    int n_asserts = 0;
    int n_fail    = 0;

    axi_sram_write_slave_if #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
    ) bus ();

    axi_sram_write_slave #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MEM_AW(MEM_AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .SRAM_CS  (sram_cs),
        .SRAM_WEB (sram_web),
        .SRAM_A   (sram_a),
        .SRAM_DI  (sram_di)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sram(input string tag, input logic cs, input logic [3:0] web,
                              input logic [MEM_AW-1:0] a, input logic [DATA_W-1:0] di);
        check({tag, ".cs"},  sram_cs,  cs);
        check({tag, ".web"}, sram_web, web);
        check({tag, ".a"},   sram_a,   a);
        check({tag, ".di"},  sram_di,  di);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".awready"}, bus.AWREADY, 1'b0);
        check({tag, ".wready"},  bus.WREADY,  1'b0);
        check({tag, ".bvalid"},  bus.BVALID,  1'b0);
        check({tag, ".bid"},     bus.BID,     8'h00);
        check({tag, ".bresp"},   bus.BRESP,   2'b00);
        check_sram(tag, 1'b0, 4'hF, '0, '0);
    endtask

    // AW handshake; starts and ends just after a rising edge with AWREADY=1.
    task automatic do_aw(input string tag, input logic [7:0] id,
                         input logic [31:0] addr, input logic [3:0] len);
        bus.AWID    = id;
        bus.AWADDR  = addr;
        bus.AWLEN   = len;
        bus.AWVALID = 1'b1;
        @(negedge clk);
        check({tag, ".awready"}, bus.AWREADY, 1'b1);
        check({tag, ".wready0"}, bus.WREADY,  1'b0);
        cyc();
        bus.AWVALID = 1'b0;
    endtask

    // One W beat with the SRAM port expected in the same cycle.
    task automatic w_beat(input string tag, input logic [31:0] data, input logic [3:0] strb,
                          input logic last, input logic exp_cs, input logic [3:0] exp_web,
                          input logic [MEM_AW-1:0] exp_a, input logic [31:0] exp_di);
        bus.WDATA  = data;
        bus.WSTRB  = strb;
        bus.WLAST  = last;
        bus.WVALID = 1'b1;
        @(negedge clk);
        check({tag, ".wready"}, bus.WREADY, 1'b1);
        check_sram(tag, exp_cs, exp_web, exp_a, exp_di);
        cyc();
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
    endtask

    // B response held for 'hold' cycles with BREADY low, then accepted.
    task automatic b_resp(input string tag, input logic [7:0] id, input logic [1:0] resp,
                          input int hold);
        bus.BREADY = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold.bvalid"},  bus.BVALID,  1'b1);
            check({tag, ".hold.awready"}, bus.AWREADY, 1'b0);
            check({tag, ".hold.bresp"},   bus.BRESP,   resp);
            cyc();
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        check({tag, ".bvalid"},  bus.BVALID,  1'b1);
        check({tag, ".bid"},     bus.BID,     id);
        check({tag, ".bresp"},   bus.BRESP,   resp);
        check({tag, ".wready"},  bus.WREADY,  1'b0);
        check({tag, ".awready"}, bus.AWREADY, 1'b0);
        check_sram({tag, ".idle"}, 1'b0, 4'hF, '0, '0);
        cyc();
        bus.BREADY = 1'b0;
        @(negedge clk);
        check({tag, ".awready_after"}, bus.AWREADY, 1'b1);
        check({tag, ".bvalid_after"},  bus.BVALID,  1'b0);
        cyc();
    endtask

    initial begin
        rst         = 1'b1;
        bus.AWID    = '0;
        bus.AWADDR  = '0;
        bus.AWLEN   = '0;
        bus.AWSIZE  = 3'd2;
        bus.AWBURST = 2'b01;
        bus.AWVALID = 1'b0;
        bus.WDATA   = '0;
        bus.WSTRB   = '0;
        bus.WLAST   = 1'b0;
        bus.WVALID  = 1'b0;
        bus.BREADY  = 1'b0;

        // Reset and the cycle after it
        cyc();
        cyc();
        @(negedge clk);
        check_reset_vals("rst");
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_after");
        cyc();
        @(negedge clk);
        check("rst_awready_rise", bus.AWREADY, 1'b1);
        cyc();

        // Single beat
        do_aw("single", 8'h15, 32'h0000_0010, 4'd0);
        w_beat("single.w", 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 4'h0, 14'h0004, 32'hDEAD_BEEF);
        b_resp("single.b", 8'h15, 2'b00, 0);

        // INCR burst, four back-to-back beats
        do_aw("incr", 8'h21, 32'h0000_0100, 4'd3);
        w_beat("incr.w0", 32'h1111_0000, 4'b0101, 1'b0, 1'b1, 4'b1010, 14'h0040, 32'h1111_0000);
        w_beat("incr.w1", 32'h2222_0001, 4'b0101, 1'b0, 1'b1, 4'b1010, 14'h0041, 32'h2222_0001);
        w_beat("incr.w2", 32'h3333_0002, 4'b0101, 1'b0, 1'b1, 4'b1010, 14'h0042, 32'h3333_0002);
        w_beat("incr.w3", 32'h4444_0003, 4'b0101, 1'b1, 1'b1, 4'b1010, 14'h0043, 32'h4444_0003);
        b_resp("incr.b", 8'h21, 2'b00, 0);

        // Backpressure: gap cycles on W, BREADY low for 5 cycles
        do_aw("bp", 8'h2A, 32'h0000_0200, 4'd1);
        bus.WDATA = 32'hCAFE_F00D;
        bus.WSTRB = 4'hF;
        @(negedge clk);
        check("bp.gap0.wready", bus.WREADY, 1'b1);
        check_sram("bp.gap0", 1'b0, 4'hF, '0, '0);
        cyc();
        w_beat("bp.w0", 32'hA5A5_0000, 4'hF, 1'b0, 1'b1, 4'h0, 14'h0080, 32'hA5A5_0000);
        bus.WDATA = 32'hFFFF_FFFF;
        @(negedge clk);
        check_sram("bp.gap1", 1'b0, 4'hF, '0, '0);
        cyc();
        w_beat("bp.w1", 32'hA5A5_0001, 4'hC, 1'b1, 1'b1, 4'h3, 14'h0081, 32'hA5A5_0001);
        b_resp("bp.b", 8'h2A, 2'b00, 5);

        // Early WLAST: AWLEN=1, last on beat 0
        do_aw("early", 8'h03, 32'h0000_0300, 4'd1);
        w_beat("early.w0", 32'h0BAD_0000, 4'hF, 1'b1, 1'b1, 4'h0, 14'h00C0, 32'h0BAD_0000);
        b_resp("early.b", 8'h03, 2'b10, 0);

        // Late WLAST: AWLEN=0, last on beat 2; beats 1 and 2 drained without write
        do_aw("late", 8'h04, 32'h0000_0400, 4'd0);
        w_beat("late.w0", 32'h7777_0000, 4'hF, 1'b0, 1'b1, 4'h0, 14'h0100, 32'h7777_0000);
        w_beat("late.w1", 32'h7777_0001, 4'hF, 1'b0, 1'b0, 4'hF, 14'h0000, 32'h0000_0000);
        w_beat("late.w2", 32'h7777_0002, 4'hF, 1'b1, 1'b0, 4'hF, 14'h0000, 32'h0000_0000);
        b_resp("late.b", 8'h04, 2'b10, 0);

        // Word-index wrap, second beat with WSTRB=0 (CS high, no byte enabled)
        do_aw("wrap", 8'h5C, 32'h0000_FFFC, 4'd1);
        w_beat("wrap.w0", 32'h1234_5678, 4'hF, 1'b0, 1'b1, 4'h0, 14'h3FFF, 32'h1234_5678);
        w_beat("wrap.w1", 32'h9ABC_DEF0, 4'h0, 1'b1, 1'b1, 4'hF, 14'h0000, 32'h9ABC_DEF0);
        b_resp("wrap.b", 8'h5C, 2'b00, 0);

        // Reset mid-burst after beat 1 of AWLEN=3
        do_aw("mrst", 8'h07, 32'h0000_0500, 4'd3);
        w_beat("mrst.w0", 32'h5555_0000, 4'hF, 1'b0, 1'b1, 4'h0, 14'h0140, 32'h5555_0000);
        w_beat("mrst.w1", 32'h5555_0001, 4'hF, 1'b0, 1'b1, 4'h0, 14'h0141, 32'h5555_0001);
        rst        = 1'b1;
        bus.WDATA  = 32'h5555_0002;
        bus.WVALID = 1'b1;
        @(negedge clk);
        check_sram("mrst.blocked", 1'b0, 4'hF, '0, '0);
        cyc();
        @(negedge clk);
        check_reset_vals("mrst.in_rst");
        cyc();
        rst        = 1'b0;
        bus.WVALID = 1'b0;
        @(negedge clk);
        check_reset_vals("mrst.after");
        cyc();
        @(negedge clk);
        check("mrst.awready_rise", bus.AWREADY, 1'b1);
        check("mrst.no_bvalid",    bus.BVALID,  1'b0);
        cyc();
        do_aw("post", 8'h33, 32'h0000_0020, 4'd0);
        w_beat("post.w", 32'h600D_600D, 4'hF, 1'b1, 1'b1, 4'h0, 14'h0008, 32'h600D_600D);
        b_resp("post.b", 8'h33, 2'b00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule
